// File: rtl/fc_scm_responder.sv
// rtl/fc_scm_responder.sv - two-port round-robin TCDM responder in front of a single-port word memory
// Fixed-latency, in-order responses; out-of-range accesses answer with an error word.
module fc_scm_responder #(
   parameter int unsigned NUM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
   parameter int unsigned LATENCY   = 1,
   parameter logic [31:0] ERR_RDATA = 32'hBADA_CCE5
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        p0_req_i,
   input  logic [31:0] p0_add_i,
   input  logic        p0_wen_i,
   input  logic [31:0] p0_wdata_i,
   input  logic [3:0]  p0_be_i,
   output logic        p0_gnt_o,
   output logic        p0_r_valid_o,
   output logic [31:0] p0_r_rdata_o,
   output logic        p0_r_opc_o,

   input  logic        p1_req_i,
   input  logic [31:0] p1_add_i,
   input  logic        p1_wen_i,
   input  logic [31:0] p1_wdata_i,
   input  logic [3:0]  p1_be_i,
   output logic        p1_gnt_o,
   output logic        p1_r_valid_o,
   output logic [31:0] p1_r_rdata_o,
   output logic        p1_r_opc_o
);

   localparam int unsigned AW        = $clog2(NUM_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(NUM_WORDS) << 2;

   logic [31:0] mem_q [NUM_WORDS];

   logic rr_ptr_q, rr_ptr_d;

   logic [LATENCY-1:0]       valid_q, valid_d;
   logic [LATENCY-1:0]       port_q,  port_d;
   logic [LATENCY-1:0]       opc_q,   opc_d;
   logic [LATENCY-1:0][31:0] rdata_q, rdata_d;

   logic          gnt0, gnt1, any_gnt;
   logic [31:0]   sel_add, sel_wdata, sel_off;
   logic          sel_wen;
   logic [3:0]    sel_be;
   logic          in_range;
   logic [AW-1:0] word_idx;
   logic          mem_we;
   logic [31:0]   rsp_rdata;
   logic          rsp_opc;

   // Pointer names the port that wins a tie; a lone requester still gets through.
   always_comb begin
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      rr_ptr_d = rr_ptr_q;
      if (!rst_i) begin
         if (p0_req_i && (!p1_req_i || !rr_ptr_q)) begin
            gnt0 = 1'b1;
         end else if (p1_req_i) begin
            gnt1 = 1'b1;
         end
      end
      if (gnt0) begin
         rr_ptr_d = 1'b1;
      end else if (gnt1) begin
         rr_ptr_d = 1'b0;
      end
   end

   assign any_gnt  = gnt0 | gnt1;
   assign p0_gnt_o = gnt0;
   assign p1_gnt_o = gnt1;

   always_comb begin
      sel_add   = gnt1 ? p1_add_i   : p0_add_i;
      sel_wen   = gnt1 ? p1_wen_i   : p0_wen_i;
      sel_wdata = gnt1 ? p1_wdata_i : p0_wdata_i;
      sel_be    = gnt1 ? p1_be_i    : p0_be_i;
      sel_off   = sel_add - BASE_ADDR;
      in_range  = (sel_add >= BASE_ADDR) && (sel_off < MEM_BYTES);
      word_idx  = sel_off[AW+1:2];
      mem_we    = any_gnt && in_range && !sel_wen;
      rsp_opc   = !in_range;
      if (!in_range) begin
         rsp_rdata = ERR_RDATA;
      end else if (sel_wen) begin
         rsp_rdata = mem_q[word_idx];
      end else begin
         rsp_rdata = 32'h0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (sel_be[b]) begin
               mem_q[word_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Stage 0 captures the granted access; the last stage drives the ports.
   always_comb begin
      valid_d    = '0;
      port_d     = '0;
      opc_d      = '0;
      rdata_d    = '0;
      valid_d[0] = any_gnt;
      port_d[0]  = gnt1;
      opc_d[0]   = rsp_opc;
      rdata_d[0] = rsp_rdata;
      for (int i = 1; i < LATENCY; i++) begin
         valid_d[i] = valid_q[i-1];
         port_d[i]  = port_q[i-1];
         opc_d[i]   = opc_q[i-1];
         rdata_d[i] = rdata_q[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= 1'b0;
         valid_q  <= '0;
         port_q   <= '0;
         opc_q    <= '0;
         rdata_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         valid_q  <= valid_d;
         port_q   <= port_d;
         opc_q    <= opc_d;
         rdata_q  <= rdata_d;
      end
   end

   assign p0_r_valid_o = valid_q[LATENCY-1] && !port_q[LATENCY-1];
   assign p1_r_valid_o = valid_q[LATENCY-1] &&  port_q[LATENCY-1];
   assign p0_r_rdata_o = p0_r_valid_o ? rdata_q[LATENCY-1] : 32'h0;
   assign p1_r_rdata_o = p1_r_valid_o ? rdata_q[LATENCY-1] : 32'h0;
   assign p0_r_opc_o   = p0_r_valid_o && opc_q[LATENCY-1];
   assign p1_r_opc_o   = p1_r_valid_o && opc_q[LATENCY-1];

endmodule
